// File: rtl/tlb_search_arbiter.sv
// tlb_search_arbiter: shares one TLB search port among fetch, mem and csr requesters.
// Optional macro TLB_ARB_RR_EN selects round-robin; otherwise fixed priority with fetch starvation override.
package tlb_search_arbiter_pkg;
  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } tlb_result_t;
endpackage

module tlb_search_arbiter
  import tlb_search_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tlb_busy,
  input  logic        flush_fetch,
  input  logic        fetch_req,
  input  logic [18:0] fetch_vppn,
  input  logic        fetch_va_bit12,
  input  logic [9:0]  fetch_asid,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output tlb_result_t fetch_result,
  input  logic        mem_req,
  input  logic [18:0] mem_vppn,
  input  logic        mem_va_bit12,
  input  logic [9:0]  mem_asid,
  output logic        mem_gnt,
  output logic        mem_rvalid,
  output tlb_result_t mem_result,
  input  logic        csr_req,
  input  logic [18:0] csr_vppn,
  input  logic        csr_va_bit12,
  input  logic [9:0]  csr_asid,
  output logic        csr_gnt,
  output logic        csr_rvalid,
  output tlb_result_t csr_result,
  output logic [18:0] tlb_s_vppn,
  output logic        tlb_s_va_bit12,
  output logic [9:0]  tlb_s_asid,
  input  tlb_result_t tlb_s_result
);
  localparam logic [1:0] FETCH = 2'd0, MEM = 2'd1, CSR = 2'd2, NONE = 2'd3;

  logic [1:0]  win, own_q, own_d;
  logic [2:0]  req;
  tlb_result_t res_q, res_d;

  assign req = {csr_req, mem_req, fetch_req};

`ifdef TLB_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d, c1, c2;
  // ptr_q is the last winner; search starts at the requester after it
  always_comb begin
    c1    = (ptr_q == CSR) ? FETCH : ptr_q + 2'd1;
    c2    = (c1 == CSR) ? FETCH : c1 + 2'd1;
    win   = tlb_busy ? NONE : req[c1] ? c1 : req[c2] ? c2 : req[ptr_q] ? ptr_q : NONE;
    ptr_d = (win == NONE) ? ptr_q : win;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ptr_q <= FETCH;
    else         ptr_q <= ptr_d;
`else
  logic [3:0] starve_q, starve_d;
  logic       starve;
  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_bad_lim
    $error("STARVE_LIM must be in 1..15");
  end
  always_comb begin
    starve   = starve_q >= 4'(STARVE_LIM);
    win      = tlb_busy ? NONE : (starve && fetch_req) ? FETCH : mem_req ? MEM :
               csr_req ? CSR : fetch_req ? FETCH : NONE;
    starve_d = (tlb_busy || !fetch_req || win == FETCH) ? 4'd0 :
               (&starve_q) ? starve_q : starve_q + 4'd1;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) starve_q <= '0;
    else         starve_q <= starve_d;
`endif

  assign fetch_gnt = win == FETCH;
  assign mem_gnt   = win == MEM;
  assign csr_gnt   = win == CSR;

  // No grant leaves the port on the fetch fields so it never floats
  assign tlb_s_vppn     = mem_gnt ? mem_vppn : csr_gnt ? csr_vppn : fetch_vppn;
  assign tlb_s_va_bit12 = mem_gnt ? mem_va_bit12 : csr_gnt ? csr_va_bit12 : fetch_va_bit12;
  assign tlb_s_asid     = mem_gnt ? mem_asid : csr_gnt ? csr_asid : fetch_asid;

  // A fetch granted under flush is recorded as having no owner
  always_comb begin
    own_d = (fetch_gnt && flush_fetch) ? NONE : win;
    res_d = (win == NONE) ? res_q : tlb_s_result;
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      own_q <= NONE;
      res_q <= '0;
    end else begin
      own_q <= own_d;
      res_q <= res_d;
    end

  assign fetch_rvalid = own_q == FETCH && !flush_fetch;
  assign mem_rvalid   = own_q == MEM;
  assign csr_rvalid   = own_q == CSR;
  assign fetch_result = res_q;
  assign mem_result   = res_q;
  assign csr_result   = res_q;
endmodule
